fifo_rr_arbiter: RTL and testbench

Round-robin pop scheduler between four 6-bit input FIFOs and four 6-bit output FIFOs of the same FIFO family. Each cycle it picks one non-empty input, pops it, and on the next cycle pushes the popped word into the output FIFO selected by the word's two MSBs. It stalls all traffic while any output FIFO signals pause or full, and flags words that land on a full output.

---
 rtl/fifo_rr_arbiter_pkg.sv | 15 +
 rtl/rr_grant4.sv | 29 ++
 rtl/fifo_rr_arbiter.sv | 99 +++++++++
 tb/tb_fifo_rr_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rr_arbiter_pkg.sv
// Shared constants and FSM encoding for the FIFO round-robin pop scheduler.
package fifo_rr_arbiter_pkg;

    localparam int DATA_WIDTH = 6;
    localparam int NUM_PORTS  = 4;
    localparam int DEST_MSB   = DATA_WIDTH - 1;
    localparam int DEST_LSB   = DATA_WIDTH - 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        STALL  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_grant4.sv
// Combinational 4-way round-robin picker: the first requester at or after rr_ptr wins.
module rr_grant4 (
    input  logic [3:0] req,
    input  logic [1:0] rr_ptr,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       any_gnt
);

    logic [1:0] idx;

    // NOTE: combinational logic uses blocking '=' and assigns every output a default
    // first, so the loop reads its own earlier result and no latch is inferred.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any_gnt = 1'b0;
        idx     = '0;
        for (int k = 0; k < 4; k++) begin
            idx = rr_ptr + 2'(k);
            if (!any_gnt && req[idx]) begin
                any_gnt   = 1'b1;
                gnt_idx   = idx;
                gnt[idx]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Round-robin pop scheduler: pops one non-empty input FIFO per cycle and pushes the word
// one cycle later into the output FIFO named by its two MSBs; stalls on any pause/full.
module fifo_rr_arbiter #(
    parameter int DATA_WIDTH = fifo_rr_arbiter_pkg::DATA_WIDTH,
    parameter int NUM_PORTS  = fifo_rr_arbiter_pkg::NUM_PORTS
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            enable,
    input  logic [NUM_PORTS-1:0]            In_Empty,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] In_Data,
    input  logic [NUM_PORTS-1:0]            Out_Pausa,
    input  logic [NUM_PORTS-1:0]            Out_Full,
    output logic [NUM_PORTS-1:0]            In_Pop,
    output logic [NUM_PORTS-1:0]            Out_Push,
    output logic [DATA_WIDTH-1:0]           Out_Data,
    output logic                            Idle,
    output logic                            Error_Arb
);
    import fifo_rr_arbiter_pkg::*;

    arb_state_t state, state_nxt;

    logic [1:0]           rr_ptr;
    logic [1:0]           pop_idx;
    logic [1:0]           sel_q;
    logic                 vld_q;
    logic [NUM_PORTS-1:0] req;
    logic [NUM_PORTS-1:0] gnt;
    logic [1:0]           gnt_idx;
    logic                 any_gnt;
    logic                 grant_ok;
    logic [1:0]           dest;

    // In_Pop doubles as last_mask: the input popped last cycle still shows a stale
    // non-empty flag, so it is excluded from this cycle's request.
    assign req = ~In_Empty & ~In_Pop;

    rr_grant4 u_grant (
        .req     (req),
        .rr_ptr  (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any_gnt (any_gnt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Gating on the next state keeps a pause sampled this cycle from producing a pop.
    always_comb begin
        state_nxt = ACTIVE;
        grant_ok  = 1'b0;
        if (!enable) begin
            state_nxt = IDLE;
        end else if ((|Out_Pausa) || (|Out_Full)) begin
            state_nxt = STALL;
        end
        grant_ok = (state_nxt == ACTIVE) && any_gnt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            In_Pop    <= '0;
            pop_idx   <= '0;
            rr_ptr    <= '0;
            vld_q     <= 1'b0;
            sel_q     <= '0;
            Error_Arb <= 1'b0;
        end else begin
            In_Pop <= grant_ok ? gnt : '0;
            vld_q  <= |In_Pop;
            sel_q  <= pop_idx;
            if (grant_ok) begin
                pop_idx <= gnt_idx;
                rr_ptr  <= gnt_idx + 2'd1;
            end
            if (|(Out_Push & Out_Full)) begin
                Error_Arb <= 1'b1;
            end
        end
    end

    // The popped word appears on In_Data one cycle after its pop; push it unconditionally.
    always_comb begin
        Out_Data = In_Data[sel_q*DATA_WIDTH +: DATA_WIDTH];
        dest     = Out_Data[DATA_WIDTH-1 -: 2];
        Out_Push = '0;
        Out_Push[dest] = vld_q;
    end

    assign Idle = (&In_Empty) & ~vld_q & (state != STALL);

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Self-checking bench for fifo_rr_arbiter: behavioural input FIFOs, pop/push scoreboard,
// a table of round-robin scenarios and hand-written stall, error and reset sequences.
module tb_fifo_rr_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [3:0]  in_empty;
    logic [23:0] in_data;
    logic [3:0]  out_pausa;
    logic [3:0]  out_full;
    logic [3:0]  in_pop;
    logic [3:0]  out_push;
    logic [5:0]  out_data;
    logic        idle;
    logic        error_arb;

    always #5 clk = ~clk;

    fifo_rr_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .In_Empty  (in_empty),
        .In_Data   (in_data),
        .Out_Pausa (out_pausa),
        .Out_Full  (out_full),
        .In_Pop    (in_pop),
        .Out_Push  (out_push),
        .Out_Data  (out_data),
        .Idle      (idle),
        .Error_Arb (error_arb)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Input FIFO models
    logic [5:0] mem [4][16];
    int         wr_ptr [4];
    int         rd_ptr [4];

    int         exp_pop [$];
    logic [5:0] exp_push [$];
    int         pop_cyc [$];
    int         cyc = 0;
    bit         mon_en = 1'b1;
    logic [3:0] prev_pop = 4'b0;

    task automatic update_empty();
        for (int i = 0; i < 4; i++) in_empty[i] = (wr_ptr[i] == rd_ptr[i]);
    endtask

    task automatic load(input int i, input logic [5:0] w);
        mem[i][wr_ptr[i] % 16] = w;
        wr_ptr[i]++;
        update_empty();
    endtask

    task automatic clear_fifos();
        for (int i = 0; i < 4; i++) rd_ptr[i] = wr_ptr[i];
        update_empty();
    endtask

    // One clock: monitor at the falling edge, advance the FIFO models after the rising edge.
    task automatic step();
        logic [3:0] pops;
        logic [5:0] w;
        @(negedge clk);
        cyc++;
        pops = in_pop;
        if (mon_en) begin
            if (pops != 4'b0) begin
                if (exp_pop.size() == 0) check("unexpected_pop", 32'(pops), 32'(0));
                else check("pop_order", 32'(pops), 32'(1) << exp_pop.pop_front());
                pop_cyc.push_back(cyc);
            end
            if (out_push != 4'b0 || prev_pop != 4'b0)
                check("push_follows_pop", 32'(out_push != 4'b0), 32'(prev_pop != 4'b0));
            if (out_push != 4'b0) begin
                if (exp_push.size() == 0) check("unexpected_push", 32'(out_push), 32'(0));
                else begin
                    w = exp_push.pop_front();
                    check("push_data", 32'(out_data), 32'(w));
                    check("push_dest", 32'(out_push), 32'(1) << w[5:4]);
                end
            end
            prev_pop = pops;
        end else begin
            prev_pop = 4'b0;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (pops[i] === 1'b1 && rd_ptr[i] != wr_ptr[i]) begin
                in_data[i*6 +: 6] = mem[i][rd_ptr[i] % 16];
                rd_ptr[i]++;
            end
        end
        update_empty();
        #1;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_pop.size() != 0 || exp_push.size() != 0) && n < 60) begin
            step();
            n++;
        end
        check({name, "_drained"}, 32'(exp_pop.size() + exp_push.size()), 32'(0));
        exp_pop.delete();
        exp_push.delete();
    endtask

    typedef struct {
        logic [5:0] words [4][3];
        int         n_words [4];
        int         pops [12];
        int         n_pops;
        int         stride;
    } vec_t;

    vec_t tbl [4];

    task automatic run_vec(input int e);
        int taken [4];
        int g;
        pop_cyc.delete();
        for (int i = 0; i < 4; i++) begin
            taken[i] = 0;
            for (int k = 0; k < tbl[e].n_words[i]; k++) load(i, tbl[e].words[i][k]);
        end
        for (int p = 0; p < tbl[e].n_pops; p++) begin
            g = tbl[e].pops[p];
            exp_pop.push_back(g);
            exp_push.push_back(tbl[e].words[g][taken[g]]);
            taken[g]++;
        end
        drain($sformatf("vec%0d", e));
        check($sformatf("vec%0d_pop_count", e), 32'(pop_cyc.size()), 32'(tbl[e].n_pops));
        for (int p = 1; p < pop_cyc.size(); p++)
            check($sformatf("vec%0d_stride", e), 32'(pop_cyc[p] - pop_cyc[p-1]), 32'(tbl[e].stride));
        check($sformatf("vec%0d_idle", e), 32'(idle), 32'(1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Scenario table; rr_ptr carries over from one entry to the next.
        for (int e = 0; e < 4; e++) begin
            for (int i = 0; i < 4; i++) begin
                tbl[e].n_words[i] = 0;
                for (int k = 0; k < 3; k++) tbl[e].words[i][k] = 6'h00;
            end
            for (int p = 0; p < 12; p++) tbl[e].pops[p] = 0;
        end
        // ptr 0: every input holds one word -> pops 0,1,2,3 back to back
        tbl[0].words[0][0] = 6'h05; tbl[0].words[1][0] = 6'h12;
        tbl[0].words[2][0] = 6'h23; tbl[0].words[3][0] = 6'h30;
        tbl[0].n_words = '{1, 1, 1, 1};
        tbl[0].pops[0:3] = '{0, 1, 2, 3};
        tbl[0].n_pops = 4; tbl[0].stride = 1;
        // ptr 0: single active input -> one pop every other cycle
        tbl[1].words[2][0] = 6'h0A; tbl[1].words[2][1] = 6'h1B; tbl[1].words[2][2] = 6'h3C;
        tbl[1].n_words = '{0, 0, 3, 0};
        tbl[1].pops[0:2] = '{2, 2, 2};
        tbl[1].n_pops = 3; tbl[1].stride = 2;
        // ptr 3: two inputs alternate
        tbl[2].words[1][0] = 6'h11; tbl[2].words[1][1] = 6'h21;
        tbl[2].words[3][0] = 6'h33; tbl[2].words[3][1] = 6'h03;
        tbl[2].n_words = '{0, 2, 0, 2};
        tbl[2].pops[0:3] = '{3, 1, 3, 1};
        tbl[2].n_pops = 4; tbl[2].stride = 1;
        // ptr 2: search wraps 3 -> 0
        tbl[3].words[0][0] = 6'h07; tbl[3].words[2][0] = 6'h28; tbl[3].words[3][0] = 6'h3E;
        tbl[3].n_words = '{1, 0, 1, 1};
        tbl[3].pops[0:2] = '{2, 3, 0};
        tbl[3].n_pops = 3; tbl[3].stride = 1;

        for (int i = 0; i < 4; i++) begin
            wr_ptr[i] = 0;
            rd_ptr[i] = 0;
        end
        reset     = 1'b1;
        enable    = 1'b0;
        out_pausa = 4'b0;
        out_full  = 4'b0;
        in_data   = {6'h03, 6'h02, 6'h01, 6'h2D};
        update_empty();

        // Reset state
        step();
        step();
        check("rst_in_pop", 32'(in_pop), 32'(0));
        check("rst_out_push", 32'(out_push), 32'(0));
        check("rst_idle", 32'(idle), 32'(1));
        check("rst_error", 32'(error_arb), 32'(0));
        check("rst_out_data", 32'(out_data), 32'(in_data[5:0]));

        // Enabled with every input empty
        reset  = 1'b0;
        enable = 1'b1;
        for (int n = 0; n < 3; n++) begin
            step();
            check("empty_no_pop", 32'(in_pop), 32'(0));
            check("empty_idle", 32'(idle), 32'(1));
            check("empty_error", 32'(error_arb), 32'(0));
        end

        for (int e = 0; e < 4; e++) run_vec(e);

        // Stall on Out_Pausa[1]; rr_ptr is 1 here
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 3; k++) load(i, 6'((i*3 + k) * 5));
        for (int r = 0; r < 3; r++) begin
            for (int j = 0; j < 4; j++) begin
                int g;
                g = (j + 1) % 4;
                exp_pop.push_back(g);
                exp_push.push_back(6'((g*3 + r) * 5));
            end
        end
        step();
        step();
        out_pausa = 4'b0010;
        step();
        check("stall_first_no_pop", 32'(in_pop), 32'(0));
        step();
        for (int n = 0; n < 3; n++) begin
            check("stall_no_pop", 32'(in_pop), 32'(0));
            check("stall_no_push", 32'(out_push), 32'(0));
            check("stall_not_idle", 32'(idle), 32'(0));
            step();
        end
        out_pausa = 4'b0;
        drain("stall_resume");
        check("stall_idle_after", 32'(idle), 32'(1));

        // Push onto a full output; rr_ptr is 1 here
        load(2, 6'h2A);
        exp_pop.push_back(2);
        exp_push.push_back(6'h2A);
        step();
        out_full = 4'b0100;
        check("err_before", 32'(error_arb), 32'(0));
        step();
        check("full_not_idle", 32'(idle), 32'(0));
        step();
        check("err_set", 32'(error_arb), 32'(1));
        out_full = 4'b0;
        for (int n = 0; n < 3; n++) step();
        check("err_sticky", 32'(error_arb), 32'(1));
        check("err_drained", 32'(exp_pop.size() + exp_push.size()), 32'(0));
        exp_pop.delete();
        exp_push.delete();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("err_cleared_by_reset", 32'(error_arb), 32'(0));

        // Reset during the pop cycle drops the in-flight word
        load(1, 6'h15);
        mon_en = 1'b0;
        step();
        check("mid_rst_pop", 32'(in_pop), 32'(4'b0010));
        reset = 1'b1;
        step();
        clear_fifos();
        #1;
        check("mid_rst_no_push", 32'(out_push), 32'(0));
        check("mid_rst_no_pop", 32'(in_pop), 32'(0));
        check("mid_rst_idle", 32'(idle), 32'(1));
        check("mid_rst_error", 32'(error_arb), 32'(0));
        check("mid_rst_out_data", 32'(out_data), 32'(in_data[5:0]));
        reset  = 1'b0;
        mon_en = 1'b1;
        for (int n = 0; n < 3; n++) begin
            step();
            check("post_rst_quiet", 32'(in_pop | out_push), 32'(0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
